i2c_master_wr: RTL and testbench

Single-byte I2C write initiator: START, 7-bit address + W, one data byte, STOP.
- Pairs with the team's I2C slave receiver on a shared open-drain bus (external pull-ups).
- Sits between a system-side request interface (pulse + operands) and the physical scl/sda pins.
- Generates SCL from clk using a 4-phase quarter-period timer.
- Reports ACK/NACK results.

---
 rtl/i2c_master_wr.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_master_wr.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_wr.sv
// ---------------------------------------------------------------------------
// i2c_master_wr
//
// Single-byte I2C write initiator. It sends START, the 7-bit address with
// R/W=0, one data byte, then STOP. ACK/NACK results are reported on ack_err.
// SCL is built from clk with a quarter-period timer. Each bit lasts four
// quarters of CLK_DIV clk cycles:
//   Q0, Q1 : SCL low. SDA may change only on entry to Q0.
//   Q2, Q3 : SCL released. ACK is sampled at the Q2 -> Q3 boundary.
//
// Optional feature (macro I2C_CLK_STRETCH_EN):
//   When defined, scl is synchronised and the quarter timer holds in Q2
//   while the bus still reads SCL low, so a slave may stretch the clock.
//   When undefined, scl is never sampled and the timer free-runs.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset (releases both lines at once)
//   start      request pulse, accepted only in IDLE with no done pulse
//   slave_addr 7-bit target address, latched on acceptance
//   wdata      data byte, latched on acceptance
//   busy       high from the cycle after acceptance until the done cycle
//   done       one-cycle pulse at transaction end
//   ack_err    NACK seen in the last transaction, cleared on next acceptance
//   scl, sda   open-drain bus lines (drive 0 or z)
// ---------------------------------------------------------------------------
module i2c_master_wr #(
  parameter int CLK_DIV = 250,
  localparam int CNT_W = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             ack_smp_q, ack_smp_d;
  logic             scl_low_q, scl_low_d;
  logic             sda_low_q, sda_low_d;
  logic             sda_s1_q, sda_s2_q;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       wbyte_q, wbyte_d;
  logic             freeze;
  logic             tick;
  logic             bit_end;

  // Line drive pattern for a given state/quarter, returned as
  // {scl_low, sda_low}. msb is the bit currently being shifted out.
  function automatic logic [1:0] line_drive(state_t st, logic [1:0] ph,
                                            logic msb);
    case (st)
      START:        line_drive = {ph == 2'd3, ph[1]};
      ADDR, DATA:   line_drive = {~ph[1], ~msb};
      ACK_A, ACK_D: line_drive = {~ph[1], 1'b0};
      STOP:         line_drive = {~ph[1], ph != 2'd3};
      default:      line_drive = 2'b00;
    endcase
  endfunction

`ifdef I2C_CLK_STRETCH_EN
  logic scl_s1_q, scl_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
    end
  end

  // Hold the timer in Q2 until the bus actually shows SCL high.
  assign freeze = (state_q != IDLE) && (phase_q == 2'd2) && !scl_s2_q;
`else
  logic scl_unused;
  assign scl_unused = scl;
  assign freeze     = 1'b0;
`endif

  // Two-flop synchroniser on the incoming SDA level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    ack_smp_d = ack_smp_q;
    shift_d   = shift_q;
    wbyte_d   = wbyte_q;
    tick      = (cnt_q == CNT_MAX) && !freeze;
    bit_end   = tick && (phase_q == 2'd3);

    if (state_q == IDLE) begin
      // A start coinciding with the done pulse is deliberately dropped.
      if (start && !done_q) begin
        state_d   = START;
        phase_d   = 2'd0;
        cnt_d     = '0;
        bit_d     = 3'd0;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        shift_d   = {slave_addr, 1'b0};
        wbyte_d   = wdata;
      end
    end else begin
      if (!freeze) begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) phase_d = phase_q + 2'd1;
      end
      if (tick && (phase_q == 2'd2)) ack_smp_d = sda_s2_q;

      if (bit_end) begin
        case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = 3'd0;
          end
          ADDR: begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ACK_A;
          end
          ACK_A: begin
            if (ack_smp_q) begin
              ack_err_d = 1'b1;
              state_d   = STOP;
            end else begin
              shift_d = wbyte_q;
              bit_d   = 3'd0;
              state_d = DATA;
            end
          end
          DATA: begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ACK_D;
          end
          ACK_D: begin
            if (ack_smp_q) ack_err_d = 1'b1;
            state_d = STOP;
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Line drives are registered from the next state so the pins change
    // exactly at quarter boundaries and never glitch.
    {scl_low_d, sda_low_d} = line_drive(state_d, phase_d, shift_d[7]);
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= 2'd0;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      ack_smp_q <= 1'b1;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      ack_smp_q <= ack_smp_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  // Data registers: only meaningful after a load on acceptance
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    wbyte_q <= wbyte_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl     = scl_low_q ? 1'b0 : 1'bz;
  assign sda     = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_wr
//
// Bench for i2c_master_wr with CLK_DIV=4 on a pulled-up open-drain bus.
// A behavioural slave at address 0x50 decodes START/STOP and bytes from the
// bus lines, ACKs as configured, and can stretch SCL after the address ACK.
// Expected bus bytes, ACK levels, ack_err and busy duration are derived from
// the transaction operands and the slave configuration.
// ---------------------------------------------------------------------------
module tb_i2c_master_wr;

  localparam int CLK_DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr_in = 7'h00;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, ack_err;
  wire        scl_w, sda_w;

  pullup (scl_w);
  pullup (sda_w);

  logic slave_sda_low = 1'b0;
  logic slave_scl_low = 1'b0;
  assign sda_w = slave_sda_low ? 1'b0 : 1'bz;
  assign scl_w = slave_scl_low ? 1'b0 : 1'bz;

  i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .slave_addr(addr_in),
    .wdata     (data_in),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .scl       (scl_w),
    .sda       (sda_w)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Cycle-level activity counters
  int busy_cycles = 0;
  int done_pulses = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_pulses++;
  end

  // Slave configuration (written by the stimulus only)
  logic [6:0] slv_addr      = 7'h50;
  logic       slv_present   = 1'b1;
  logic       slv_nack_data = 1'b0;
  logic       slv_stretch   = 1'b0;

  // Bus observations (written by the slave model only)
  logic [7:0] bus_bytes[$];
  logic       ack_bits[$];
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  logic [7:0] rx_data   = 8'h00;

  event stretch_ev;
  logic scl_prev = 1'b1, sda_prev = 1'b1;
  int   bitpos = 0, byte_idx = 0;
  logic [7:0] shreg = 8'h00;
  logic addr_ok = 1'b0;
  logic ack_now;

  always @(scl_w or sda_w) begin
    if (scl_prev && scl_w && sda_prev && !sda_w) begin
      start_cnt++;
      bitpos   = 0;
      byte_idx = 0;
    end else if (scl_prev && scl_w && !sda_prev && sda_w) begin
      stop_cnt++;
      bitpos        = 0;
      slave_sda_low = 1'b0;
    end else if (!scl_prev && scl_w) begin
      if (bitpos < 8) begin
        shreg = {shreg[6:0], sda_w};
        bitpos++;
      end else if (bitpos == 8) begin
        ack_bits.push_back(sda_w);
        bitpos = 9;
      end
    end else if (scl_prev && !scl_w) begin
      if (bitpos == 8) begin
        bus_bytes.push_back(shreg);
        if (byte_idx == 0)
          addr_ok = slv_present && (shreg[7:1] == slv_addr) && !shreg[0];
        ack_now = (byte_idx == 0) ? addr_ok : (addr_ok && !slv_nack_data);
        if (ack_now && byte_idx == 1) rx_data = shreg;
        slave_sda_low = ack_now;
        byte_idx++;
      end else if (bitpos == 9) begin
        slave_sda_low = 1'b0;
        bitpos        = 0;
        if (byte_idx == 1 && addr_ok && slv_stretch) -> stretch_ev;
      end
    end
    scl_prev = scl_w;
    sda_prev = sda_w;
  end

  // Slave clock stretch: hold SCL low for 50 cycles
  always begin
    @(stretch_ev);
    @(posedge clk);
    slave_scl_low = 1'b1;
    repeat (50) @(posedge clk);
    slave_scl_low = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction checked against the expected bus behaviour.
  task automatic txn(input logic [6:0] a, input logic [7:0] d,
                     input bit poke, input bit stretch);
    logic [7:0] exp_bytes[$];
    logic       exp_acks[$];
    bit         addr_ack, exp_err, got;
    int         exp_busy, b0, d0, bb0, ab0, st0, sp0, span;

    addr_ack = slv_present && (a == slv_addr);
    exp_bytes.push_back({a, 1'b0});
    exp_acks.push_back(!addr_ack);
    if (addr_ack) begin
      exp_bytes.push_back(d);
      exp_acks.push_back(slv_nack_data);
    end
    exp_err  = !addr_ack || slv_nack_data;
    exp_busy = addr_ack ? (80 * CLK_DIV + SYNC_EXTRA * 19)
                        : (44 * CLK_DIV + SYNC_EXTRA * 10);

    b0  = busy_cycles;
    d0  = done_pulses;
    bb0 = bus_bytes.size();
    ab0 = ack_bits.size();
    st0 = start_cnt;
    sp0 = stop_cnt;

    @(negedge clk);
    start   = 1'b1;
    addr_in = a;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("ack_err_cleared_on_accept", ack_err, 1'b0);

    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (poke && i == 60) begin
        start   = 1'b1;
        addr_in = ~a;
        data_in = ~d;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("ack_err", ack_err, exp_err);
    repeat (4) @(negedge clk);
    check("done_pulse_count", done_pulses - d0, 1);
    span = busy_cycles - b0;
    if (stretch)
      check("busy_cycles_stretched", (span >= exp_busy + 40) && (span <= exp_busy + 50), 1'b1);
    else
      check("busy_cycles", span, exp_busy);
    check("start_count", start_cnt - st0, 1);
    check("stop_count", stop_cnt - sp0, 1);
    check("bus_byte_count", bus_bytes.size() - bb0, exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) begin
      check("bus_byte", bus_bytes[bb0 + i], exp_bytes[i]);
      check("ack_bit", ack_bits[ab0 + i], exp_acks[i]);
    end
    if (addr_ack && !slv_nack_data) check("slave_rx_data", rx_data, d);
  endtask

  int st0, sp0, bb0;
  logic [6:0] ra;
  logic [7:0] rd;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ack_err", ack_err, 1'b0);
    check("reset_scl", scl_w, 1'b1);
    check("reset_sda", sda_w, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ACKed write
    txn(7'h50, 8'hA5, 1'b0, 1'b0);

    // No responder at 0x23
    slv_present = 1'b0;
    txn(7'h23, 8'h5A, 1'b0, 1'b0);
    slv_present = 1'b1;

    // Slave NACKs the data byte, then a clean transaction clears ack_err
    slv_nack_data = 1'b1;
    txn(7'h50, 8'h3C, 1'b0, 1'b0);
    slv_nack_data = 1'b0;
    txn(7'h50, 8'hC3, 1'b0, 1'b0);

    // start pulsed mid-transaction with other operands is ignored
    txn(7'h50, 8'h69, 1'b1, 1'b0);

    // Reset during DATA bit 3
    st0 = start_cnt;
    sp0 = stop_cnt;
    bb0 = bus_bytes.size();
    @(negedge clk);
    start   = 1'b1;
    addr_in = 7'h50;
    data_in = 8'h96;
    @(negedge clk);
    start = 1'b0;
    repeat (210) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scl", scl_w, 1'b1);
    check("midrst_sda", sda_w, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_no_stop", stop_cnt - sp0, 0);
    check("midrst_addr_only", bus_bytes.size() - bb0, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    txn(7'h50, 8'h96, 1'b0, 1'b0);

    // Randomised transactions
    for (int k = 0; k < 5; k++) begin
      ra = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      slv_nack_data = 1'($urandom_range(0, 1));
      txn(ra, rd, 1'b0, 1'b0);
    end
    slv_nack_data = 1'b0;

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 50 cycles after the address ACK
    slv_stretch = 1'b1;
    txn(7'h50, 8'hE7, 1'b0, 1'b1);
    slv_stretch = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
